// File: rtl/fw_ctrl_unit.sv
// EX-stage operand forwarding decision unit: tracks the two in-flight destinations
// (EX, MEM), registers the bypass select for the instruction entering EX, and flags load-use hazards.
package core;
  typedef enum logic [1:0] {
    NONE_STAGE = 2'd0,
    MEM_STAGE  = 2'd1,
    WB_STAGE   = 2'd2
  } fw_stage_e;

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS1     = 2'd1,
    RS2     = 2'd2,
    RS_BOTH = 2'd3
  } fw_regs_e;

  typedef struct packed {
    fw_stage_e stage;
    fw_regs_e  regs;
    fw_stage_e rs1;
    fw_stage_e rs2;
  } fw_cntrl_bus_t;
endpackage

module fw_ctrl_unit
  import core::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_we_i,
  input  logic              id_load_i,
  output fw_cntrl_bus_t     fw_cntrl_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } sb_entry_t;

  localparam fw_cntrl_bus_t FW_RESET = '{NONE_STAGE, RS_NONE, NONE_STAGE, NONE_STAGE};
  localparam sb_entry_t     SB_EMPTY = '{1'b0, '0, 1'b0, 1'b0};

  sb_entry_t        ex_e_reg, mem_e_reg;
  fw_cntrl_bus_t    fw_reg, fw_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic              ex_writing, mem_writing;
  logic [REG_AW-1:0] src_idx [2];
  logic              src_use [2];
  logic              hit_m   [2];
  logic              hit_w   [2];
  fw_stage_e         src_sel [2];
  logic              load_use;
  logic              kill_ex;

  assign ex_writing  = ex_e_reg.valid && ex_e_reg.we && (ex_e_reg.rd != '0);
  assign mem_writing = mem_e_reg.valid && mem_e_reg.we && (mem_e_reg.rd != '0);

  assign src_idx[0] = id_rs1_i;
  assign src_idx[1] = id_rs2_i;
  assign src_use[0] = id_use_rs1_i;
  assign src_use[1] = id_use_rs2_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic considered;
      assign considered  = src_use[gi] && (src_idx[gi] != '0);
      assign hit_m[gi]   = considered && ex_writing && (ex_e_reg.rd == src_idx[gi]);
      assign hit_w[gi]   = considered && mem_writing && (mem_e_reg.rd == src_idx[gi]);
      // The younger producer (in EX now, MEM next) carries the newest value.
      assign src_sel[gi] = hit_m[gi] ? MEM_STAGE : (hit_w[gi] ? WB_STAGE : NONE_STAGE);
    end
  endgenerate

  // A load's data only exists at WB, so a MEM-distance consumer must wait one bubble.
  assign load_use = id_valid_i && !flush_i && !hold_i && ex_writing && ex_e_reg.load
                    && (hit_m[0] || hit_m[1]);
  assign stall_o  = load_use;
  assign kill_ex  = flush_i || load_use || !id_valid_i;

  always_comb begin
    fw_next     = FW_RESET;
    fw_next.rs1 = src_sel[0];
    fw_next.rs2 = src_sel[1];
    unique case ({src_sel[1] != NONE_STAGE, src_sel[0] != NONE_STAGE})
      2'b01:   fw_next.regs = RS1;
      2'b10:   fw_next.regs = RS2;
      2'b11:   fw_next.regs = RS_BOTH;
      default: fw_next.regs = RS_NONE;
    endcase
    if (fw_next.regs == RS_NONE)
      fw_next.stage = NONE_STAGE;
    else if (src_sel[0] == MEM_STAGE || src_sel[1] == MEM_STAGE)
      fw_next.stage = MEM_STAGE;
    else
      fw_next.stage = WB_STAGE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_e_reg      <= SB_EMPTY;
      mem_e_reg     <= SB_EMPTY;
      fw_reg        <= FW_RESET;
      stall_cnt_reg <= '0;
    end else if (!hold_i) begin
      mem_e_reg <= ex_e_reg;
      if (kill_ex) begin
        ex_e_reg <= SB_EMPTY;
        fw_reg   <= FW_RESET;
      end else begin
        ex_e_reg <= '{1'b1, id_rd_i, id_we_i, id_load_i};
        fw_reg   <= fw_next;
      end
      if (load_use && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign fw_cntrl_o  = fw_reg;
  assign stall_cnt_o = stall_cnt_reg;

endmodule
